// File: rtl/key_event_dispatch.sv
// Key-press event extractor with a broadcast FIFO (two consumers, each served once per event)
// and an idle-frame timer that pulses seq_abort for the cheat-sequence detector.
module key_event_dispatch #(
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_FRAMES = 120
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     game_frame_clk_rising_edge,
   input  logic [7:0]               keycode,
   output logic                     cheat_valid,
   input  logic                     cheat_ready,
   output logic                     move_valid,
   input  logic                     move_ready,
   output logic [7:0]               event_key,
   output logic                     seq_abort,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = $clog2(TIMEOUT_FRAMES + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [PW-1:0] P_ONE    = PW'(1);
   localparam logic [TW-1:0] T_MAX    = TW'(TIMEOUT_FRAMES);
   localparam logic [TW-1:0] T_ONE    = TW'(1);

   typedef enum logic {ST_ARMED, ST_EXPIRED} tstate_t;

   logic [7:0]    r_prev_key;
   logic [7:0]    r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_cheat_done;
   logic          r_move_done;
   logic          r_overflow;
   logic [TW-1:0] r_frame_cnt;
   tstate_t       r_tstate;
   logic          r_abort;

   logic          w_press;
   logic          w_empty;
   logic          w_full;
   logic          w_cheat_hs;
   logic          w_move_hs;
   logic          w_pop;
   logic          w_push;
   tstate_t       w_nstate;
   logic [TW-1:0] w_ncnt;
   logic          w_nabort;

   assign w_press    = (keycode != 8'd0) && (keycode != r_prev_key);
   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == FULL_CNT);
   assign w_cheat_hs = cheat_valid && cheat_ready;
   assign w_move_hs  = move_valid && move_ready;
   // Pop once both consumers have the head, whether accepted earlier or right now.
   assign w_pop      = !w_empty && (r_cheat_done || w_cheat_hs) && (r_move_done || w_move_hs);
   assign w_push     = w_press && (!w_full || w_pop);

   assign cheat_valid = !w_empty && !r_cheat_done;
   assign move_valid  = !w_empty && !r_move_done;
   assign event_key   = w_empty ? '0 : r_mem[r_rd_ptr];
   assign seq_abort   = r_abort;
   assign overflow    = r_overflow;
   assign fifo_count  = r_count;

   always_ff @(posedge Clk) begin
      if (w_push) r_mem[r_wr_ptr] <= keycode;
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_prev_key   <= '0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_cheat_done <= 1'b0;
         r_move_done  <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_prev_key <= keycode;
         if (w_push) r_wr_ptr <= r_wr_ptr + P_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + P_ONE;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
         if (w_press && w_full && !w_pop) r_overflow <= 1'b1;
         if (w_pop) begin
            r_cheat_done <= 1'b0;
            r_move_done  <= 1'b0;
         end else begin
            if (w_cheat_hs) r_cheat_done <= 1'b1;
            if (w_move_hs)  r_move_done  <= 1'b1;
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_tstate    <= ST_ARMED;
         r_frame_cnt <= '0;
         r_abort     <= 1'b0;
      end else begin
         r_tstate    <= w_nstate;
         r_frame_cnt <= w_ncnt;
         r_abort     <= w_nabort;
      end
   end

   // A press wins over an expiring frame edge: counter restarts and no pulse is issued.
   always_comb begin
      w_nstate = r_tstate;
      w_ncnt   = r_frame_cnt;
      w_nabort = 1'b0;
      if (w_press) begin
         w_nstate = ST_ARMED;
         w_ncnt   = '0;
      end else begin
         unique case (r_tstate)
            ST_ARMED: begin
               if (game_frame_clk_rising_edge) begin
                  if (r_frame_cnt + T_ONE == T_MAX) begin
                     w_ncnt   = T_MAX;
                     w_nstate = ST_EXPIRED;
                     w_nabort = 1'b1;
                  end else begin
                     w_ncnt = r_frame_cnt + T_ONE;
                  end
               end
            end
            ST_EXPIRED: ;
            default: w_nstate = ST_ARMED;
         endcase
      end
   end

endmodule

// File: tb/tb_key_event_dispatch.sv
// Directed bench for key_event_dispatch (DEPTH=4, TIMEOUT_FRAMES=3): press detection,
// broadcast handshake, overflow, full push+pop, inactivity abort and async reset.
module tb_key_event_dispatch;

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic       frame = 1'b0;
   logic [7:0] key = 8'd0;
   logic       cr = 1'b0;
   logic       mr = 1'b0;
   logic       cheat_valid;
   logic       move_valid;
   logic [7:0] event_key;
   logic       seq_abort;
   logic       overflow;
   logic [2:0] fifo_count;

   int n_checks = 0;
   int n_err    = 0;

   key_event_dispatch #(.DEPTH(4), .TIMEOUT_FRAMES(3)) dut (
      .Clk                        (Clk),
      .Reset                      (Reset),
      .game_frame_clk_rising_edge (frame),
      .keycode                    (key),
      .cheat_valid                (cheat_valid),
      .cheat_ready                (cr),
      .move_valid                 (move_valid),
      .move_ready                 (mr),
      .event_key                  (event_key),
      .seq_abort                  (seq_abort),
      .overflow                   (overflow),
      .fifo_count                 (fifo_count)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag, input logic [2:0] cnt, input logic cv,
                            input logic mv, input logic [7:0] k);
      chk({tag, ".count"}, 32'(fifo_count), 32'(cnt));
      chk({tag, ".cv"},    32'(cheat_valid), 32'(cv));
      chk({tag, ".mv"},    32'(move_valid), 32'(mv));
      chk({tag, ".key"},   32'(event_key), 32'(k));
   endtask

   task automatic frame_pulse();
      repeat (4) tick();
      frame = 1'b1;
      tick();
      frame = 1'b0;
   endtask

   initial begin
      // reset state
      tick();
      chk_state("rst", 3'd0, 1'b0, 1'b0, 8'd0);
      chk("rst.abort", 32'(seq_abort), 32'd0);
      chk("rst.ovf", 32'(overflow), 32'd0);
      Reset = 1'b1;
      tick();

      // inactivity timeout: abort on 3rd pulse only
      cr = 1'b1; mr = 1'b1;
      for (int p = 1; p <= 6; p++) begin
         frame_pulse();
         chk($sformatf("abort.p%0d", p), 32'(seq_abort), (p == 3) ? 32'd1 : 32'd0);
         if (p == 3) begin
            tick();
            chk("abort.one_cycle", 32'(seq_abort), 32'd0);
         end
      end
      key = 8'd29;
      tick();
      key = 8'd0;
      chk("abort.press", 32'(seq_abort), 32'd0);
      for (int p = 1; p <= 3; p++) begin
         frame_pulse();
         chk($sformatf("abort2.p%0d", p), 32'(seq_abort), (p == 3) ? 32'd1 : 32'd0);
      end
      tick();
      chk("abort2.one_cycle", 32'(seq_abort), 32'd0);
      chk("abort2.drained", 32'(fifo_count), 32'd0);
      cr = 1'b0; mr = 1'b0;

      // held key -> one event
      key = 8'd82;
      tick();
      chk_state("hold.c1", 3'd1, 1'b1, 1'b1, 8'd82);
      repeat (9) tick();
      chk_state("hold.c10", 3'd1, 1'b1, 1'b1, 8'd82);
      key = 8'd0;
      tick();
      chk("hold.release", 32'(fifo_count), 32'd1);
      cr = 1'b1; mr = 1'b1;
      tick();
      chk_state("hold.pop", 3'd0, 1'b0, 1'b0, 8'd0);

      // direct changes, movement stalled
      mr = 1'b0;
      key = 8'd82;
      tick();
      chk_state("chg.e1", 3'd1, 1'b1, 1'b1, 8'd82);
      key = 8'd81;
      tick();
      chk_state("chg.e2", 3'd2, 1'b0, 1'b1, 8'd82);
      key = 8'd80;
      tick();
      chk_state("chg.e3", 3'd3, 1'b0, 1'b1, 8'd82);
      key = 8'd0;
      mr = 1'b1;
      tick();
      chk_state("chg.f1", 3'd2, 1'b1, 1'b1, 8'd81);
      tick();
      chk_state("chg.f2", 3'd1, 1'b1, 1'b1, 8'd80);
      tick();
      chk_state("chg.f3", 3'd0, 1'b0, 1'b0, 8'd0);

      // full FIFO with simultaneous push and pop
      cr = 1'b0; mr = 1'b0;
      for (int k = 20; k <= 23; k++) begin
         key = 8'(k);
         tick();
      end
      chk_state("full.fill", 3'd4, 1'b1, 1'b1, 8'd20);
      key = 8'd24;
      cr = 1'b1; mr = 1'b1;
      tick();
      chk_state("full.pushpop", 3'd4, 1'b1, 1'b1, 8'd21);
      chk("full.ovf", 32'(overflow), 32'd0);
      tick();
      chk("full.d1", 32'(event_key), 32'd22);
      tick();
      chk("full.d2", 32'(event_key), 32'd23);
      tick();
      chk("full.d3", 32'(event_key), 32'd24);
      tick();
      chk_state("full.empty", 3'd0, 1'b0, 1'b0, 8'd0);

      // overflow: six presses into four entries
      cr = 1'b0; mr = 1'b0;
      for (int k = 4; k <= 9; k++) begin
         key = 8'(k);
         tick();
         if (k == 7) chk("ovf.at4", 32'(overflow), 32'd0);
      end
      chk_state("ovf.full", 3'd4, 1'b1, 1'b1, 8'd4);
      chk("ovf.flag", 32'(overflow), 32'd1);
      repeat (5) tick();
      chk("ovf.sticky", 32'(overflow), 32'd1);
      cr = 1'b1; mr = 1'b1;
      tick();
      chk("ovf.h2", 32'(event_key), 32'd5);
      tick();
      chk("ovf.h3", 32'(event_key), 32'd6);
      tick();
      chk("ovf.h4", 32'(event_key), 32'd7);
      tick();
      chk_state("ovf.empty", 3'd0, 1'b0, 1'b0, 8'd0);
      chk("ovf.still", 32'(overflow), 32'd1);

      // async reset with three events queued
      cr = 1'b0; mr = 1'b0;
      key = 8'd10; tick();
      key = 8'd11; tick();
      key = 8'd12; tick();
      chk_state("ar.queued", 3'd3, 1'b1, 1'b1, 8'd10);
      #2;
      Reset = 1'b0;
      #1;
      chk_state("ar.async", 3'd0, 1'b0, 1'b0, 8'd0);
      chk("ar.ovf", 32'(overflow), 32'd0);
      chk("ar.abort", 32'(seq_abort), 32'd0);
      key = 8'd0;
      tick();
      Reset = 1'b1;
      tick();
      tick();
      chk_state("ar.after", 3'd0, 1'b0, 1'b0, 8'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/key_event_dispatch.md
Name: key_event_dispatch

Overview:
- Turns the level-valued USB keycode into discrete key-press events and buffers them in a small FIFO.
- Broadcasts each event to two consumers: the cheat-sequence detector and the player movement/fire logic. Each consumer uses a valid/ready handshake and receives each key exactly once, even if it stalls.
- Issues an inactivity abort pulse so the cheat detector can restart after a configurable number of idle game frames.

Parameters:
- DEPTH, 4, number of FIFO entries (power of two, >= 2).
- TIMEOUT_FRAMES, 120, idle game frames before seq_abort fires (>= 1).

Ports:
- Clk  input  1  system clock; all state updates on posedge.
- Reset  input  1  asynchronous, active-low reset (asserted when 0).
- game_frame_clk_rising_edge  input  1  one-Clk-cycle pulse at each game frame.
- keycode  input  8  current USB keycode; 0 = no key.
- cheat_valid  output  1  head event offered to the cheat detector.
- cheat_ready  input  1  cheat detector accepts the head event.
- move_valid  output  1  head event offered to the movement logic.
- move_ready  input  1  movement logic accepts the head event.
- event_key  output  8  keycode of the FIFO head, shared by both consumers.
- seq_abort  output  1  one-cycle pulse on inactivity timeout.
- overflow  output  1  sticky flag: an event was dropped because the FIFO was full.
- fifo_count  output  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (asynchronous, Reset=0) clears:
  - prev_key=0, FIFO pointers and count=0, delivered flags=0, frame counter=0, timer FSM=ARMED.
  - All outputs: cheat_valid=0, move_valid=0, event_key=0, seq_abort=0, overflow=0, fifo_count=0.
  - Reset mid-handshake discards all buffered events.
- Press detection: prev_key <= keycode every cycle.
  - A press event occurs in a cycle where keycode!=0 and keycode!=prev_key.
  - A held key produces one event. A direct change A->B (no 0 in between) produces an event for B. Release (->0) produces no event.
- Push: the event is written at the tail on the same edge. Latency is 1 cycle: the event is visible at the head (or fifo_count increments) in the cycle after the keycode change.
- Full FIFO:
  - A push while count==DEPTH and no pop that cycle drops the event and sets overflow=1. overflow clears only on reset.
  - Push and pop in the same cycle while full: both take effect and count stays DEPTH.
- Empty FIFO: cheat_valid=move_valid=0 and event_key=0. A new event is never bypassed to the outputs in its push cycle.
- Broadcast:
  - cheat_valid = !empty && !cheat_done; move_valid = !empty && !move_done.
  - A handshake (valid&&ready) sets the corresponding done flag.
  - Pop occurs when each consumer is either already done or handshaking this cycle. Both done flags clear on pop.
  - The head advances 1 cycle after the last acceptance. Both consumers accepting in the same cycle pops that cycle.
- Pointers wrap modulo DEPTH. event_key comes directly from the head entry (registered storage).
- Timeout FSM:
  - ARMED: counter increments on each game_frame_clk_rising_edge. When the counter reaches TIMEOUT_FRAMES, assert seq_abort for exactly one cycle and go to EXPIRED.
  - EXPIRED: counter holds, no further pulses.
  - Any press event (including a dropped one) clears the counter to 0 and returns to ARMED. An event in the same cycle as the expiring frame edge takes priority: no pulse, counter=0.
- Widths: counter width is $clog2(TIMEOUT_FRAMES+1) and saturates; it never wraps.

Test Plan:
- Reset=0 mid-operation with 3 events queued -> all outputs 0 immediately (async); after release, fifo_count=0 and no stale events appear.
- keycode 0->82 held 10 cycles ->0 -> exactly one event: event_key=82, both valids high from cycle 2; cheat_ready=move_ready=1 -> popped, fifo_count back to 0.
- keycode 82->81->80 with no zeros, move_ready=0 and cheat_ready=1 -> cheat receives 82 once (cheat_valid drops after accept), FIFO holds 82,81,80. Release move_ready -> move receives 82,81,80 in order; cheat receives 81,80 once each.
- Six distinct presses with both ready=0, DEPTH=4 -> fifo_count=4, overflow=1, and 4 head entries equal to the first four keys; keep ready=0 -> overflow stays 1.
- TIMEOUT_FRAMES=3, no keys, frame pulses every 5 cycles -> seq_abort high for one cycle at the 3rd pulse, none at the 4th-6th; press 29 then 3 more pulses -> a second single abort pulse.
- Full FIFO with both ready=1 and a new press in the same cycle -> event accepted, overflow stays 0, fifo_count stays 4.
